status_value_retire: RTL and testbench
======================================

Name: status_value_retire

Overview:
- Consumer (pull side) of the status value vector.
- Watches head entry [0]. When the head's status value reaches DONE_VALUE, it pulls the head and forwards the value downstream through a 2-entry valid/ready skid buffer.
- Also provides a flush mode that drains and discards every vector entry.
- Also provides a stuck-head timeout flag.

Parameters:
- WIDTH, 4: status value width; matches the vector's WIDTH.
- DEPTH, 8: number of vector entries; sizes flush_count_o.
- DONE_VALUE, 4'hF: head value that makes the head retirable; WIDTH bits.
- TIMEOUT, 255: cycles a valid, not-done head may wait before timeout_o fires. Must be ≥1.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- arst_n_i  input  1  asynchronous active-low reset.
- head_valid_i  input  1  valid bit of vector entry [0].
- head_value_i  input  WIDTH  status value of vector entry [0].
- empty_i  input  1  vector empty indication.
- pull_o  output  1  pull head entry; vector shifts on the same edge.
- ret_valid_o  output  1  retired value available.
- ret_value_o  output  WIDTH  retired value; equals DONE_VALUE in normal operation.
- ret_ready_i  input  1  downstream accepts ret_value_o.
- flush_i  input  1  single-cycle request to drain the vector.
- flush_busy_o  output  1  high while in FLUSH.
- flush_done_o  output  1  one-cycle pulse on flush completion.
- flush_count_o  output  $clog2(DEPTH+1)  entries discarded by the last or ongoing flush.
- timeout_o  output  1  one-cycle pulse when the head has been stuck for TIMEOUT cycles.

Behaviour:
- Reset (async assert, sync release)
  - State = RUN; skid buffer empty.
  - All outputs 0: pull_o, ret_valid_o, ret_value_o, flush_busy_o, flush_done_o, flush_count_o, timeout_o. Timeout counter 0.
  - pull_o is 0 while arst_n_i is low.
- States
  - RUN: normal retirement.
  - FLUSH: discard vector entries.
  - DONE: one cycle; flush_done_o = 1.
  - Transitions:
    - RUN→FLUSH on flush_i.
    - FLUSH→DONE when ~head_valid_i & empty_i.
    - DONE→RUN unconditionally.
    - flush_i outside RUN is ignored.
- pull_o is combinational from registered state, registered buffer count and head inputs:
  - RUN: pull_o = head_valid_i & (head_value_i == DONE_VALUE) & (buf_count < 2) & ~flush_i.
  - FLUSH: pull_o = head_valid_i.
  - DONE: pull_o = 0.
- Back-to-back pulls are legal. The vector presents the new head the cycle after a pull, so one entry can retire per cycle.
- Skid buffer (2 entries, FIFO order)
  - Write: head_value_i on a RUN pull.
  - Read: on ret_valid_o & ret_ready_i.
  - ret_valid_o = (buf_count != 0); ret_value_o = oldest entry. Both registered.
  - Simultaneous write and read: count unchanged, order preserved.
  - Full (count = 2): no pull. This is intentional backpressure on the vector.
- Flush
  - FLUSH pulls are not written to the buffer.
  - Entries already in the buffer are kept and still drain downstream.
  - flush_count_o clears to 0 on RUN→FLUSH, increments per FLUSH pull, saturates at DEPTH, holds after DONE until the next flush.
  - flush_busy_o is registered and equals (state == FLUSH).
  - Flush of an already empty vector: RUN→FLUSH→DONE→RUN, flush_count_o = 0.
- Timeout
  - Counter increments in RUN while head_valid_i & (head_value_i != DONE_VALUE).
  - Counter clears on any pull, when head is done or invalid, and in FLUSH/DONE.
  - timeout_o pulses for one cycle on the edge the counter reaches TIMEOUT. The counter then saturates with no repeat pulse until cleared.
  - A done head blocked by a full buffer does not count.
- Reset mid-flush or with a full buffer: everything clears immediately. No pull is issued, and buffered values are lost.

Test Plan:
- Basic retire: reset; head_valid_i = 1, head_value_i = 4'h3 for 3 cycles, then 4'hF; ret_ready_i = 1 → pull_o = 0 for 3 cycles, then pull_o = 1 for one cycle; ret_valid_o = 1 with ret_value_o = 4'hF the next cycle.
- Backpressure: ret_ready_i = 0, 4 done heads presented back-to-back → exactly 2 pulls, pull_o then held 0. Set ret_ready_i = 1 → remaining 2 retire, buffer order preserved, at most one pull per cycle.
- Flush: 5 valid entries with mixed values, pulse flush_i → 5 consecutive pull_o, flush_busy_o high throughout, ret_valid_o stays 0, flush_done_o pulses once, flush_count_o = 5.
- Flush with buffer occupied: 2 buffered values with ret_ready_i = 0, then flush 3 entries → flush_count_o = 3. Release ready → both original values still delivered.
- Timeout: TIMEOUT = 4, head stuck at 4'h1 → timeout_o pulses exactly once 4 cycles after head valid, no second pulse. Head changes to 4'hF → pull occurs.
- Async reset mid-flush: assert arst_n_i low during FLUSH with flush_count_o = 2 → all outputs 0 immediately. After release the block is in RUN and a new done head retires normally.

Source files
------------

// File: rtl/status_value_retire.sv
// Pull-side consumer of the status value vector: retires done heads through a
// 2-entry skid buffer, drains the vector on flush and flags a stuck head.
module status_value_retire #(
   parameter int               WIDTH      = 4,
   parameter int               DEPTH      = 8,
   parameter logic [WIDTH-1:0] DONE_VALUE = 4'hF,
   parameter int               TIMEOUT    = 255
) (
   input  logic                       clk_i,
   input  logic                       arst_n_i,
   input  logic                       head_valid_i,
   input  logic [WIDTH-1:0]           head_value_i,
   input  logic                       empty_i,
   output logic                       pull_o,
   output logic                       ret_valid_o,
   output logic [WIDTH-1:0]           ret_value_o,
   input  logic                       ret_ready_i,
   input  logic                       flush_i,
   output logic                       flush_busy_o,
   output logic                       flush_done_o,
   output logic [$clog2(DEPTH+1)-1:0] flush_count_o,
   output logic                       timeout_o,
   output logic [1:0]                 state_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] buf_q [2];
   logic [1:0]       buf_count;
   logic [CW-1:0]    flush_count;
   logic [TW-1:0]    wait_count;
   logic             timeout_q;
   logic             pull;
   logic             buf_wr, buf_rd;
   logic             stall_tick;

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (flush_i) state_d = FLUSH;
         FLUSH:   if (!head_valid_i && empty_i) state_d = DONE;
         DONE:    state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      pull = 1'b0;
      case (state_q)
         RUN:     pull = head_valid_i && (head_value_i == DONE_VALUE) &&
                         (buf_count < 2'd2) && !flush_i;
         FLUSH:   pull = head_valid_i;
         default: pull = 1'b0;
      endcase
   end

   // The vector shifts on the same edge as pull_o, so it must be silent in reset.
   assign pull_o = pull & arst_n_i;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) state_q <= RUN;
      else           state_q <= state_d;
   end

   // Downstream handshake: a value transfers on any rising edge where
   // ret_valid_o and ret_ready_i are both high; ret_valid_o/ret_value_o hold
   // steady until that happens and never depend on ret_ready_i.
   assign buf_wr = pull && (state_q == RUN);
   assign buf_rd = ret_valid_o && ret_ready_i;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         buf_q[0]  <= '0;
         buf_q[1]  <= '0;
         buf_count <= 2'd0;
      end else begin
         case ({buf_wr, buf_rd})
            2'b10: begin
               if (buf_count == 2'd0) buf_q[0] <= head_value_i;
               else                   buf_q[1] <= head_value_i;
               buf_count <= buf_count + 2'd1;
            end
            2'b01: begin
               buf_q[0]  <= buf_q[1];
               buf_count <= buf_count - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged; the incoming value lands behind the survivor.
               if (buf_count == 2'd1) begin
                  buf_q[0] <= head_value_i;
               end else begin
                  buf_q[0] <= buf_q[1];
                  buf_q[1] <= head_value_i;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         flush_count <= '0;
      end else if (state_q == RUN && flush_i) begin
         flush_count <= '0;
      end else if (state_q == FLUSH && pull && flush_count < CW'(DEPTH)) begin
         flush_count <= flush_count + 1'b1;
      end
   end

   // A done head stuck behind a full buffer is backpressure, not a stall.
   assign stall_tick = (state_q == RUN) && head_valid_i && (head_value_i != DONE_VALUE);

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         wait_count <= '0;
         timeout_q  <= 1'b0;
      end else begin
         if (!stall_tick)                    wait_count <= '0;
         else if (wait_count != TW'(TIMEOUT)) wait_count <= wait_count + 1'b1;
         timeout_q <= stall_tick && (wait_count == TW'(TIMEOUT - 1));
      end
   end

   assign ret_valid_o   = (buf_count != 2'd0);
   assign ret_value_o   = buf_q[0];
   assign flush_busy_o  = (state_q == FLUSH);
   assign flush_done_o  = (state_q == DONE);
   assign flush_count_o = flush_count;
   assign timeout_o     = timeout_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_status_value_retire.sv
// Directed bench for status_value_retire: a queue models the status vector,
// retired values and timeout pulses are collected and checked in line.
module tb_status_value_retire;

   logic       clk_i = 1'b0;
   logic       arst_n_i;
   logic       head_valid_i;
   logic [3:0] head_value_i;
   logic       empty_i;
   logic       pull_o;
   logic       ret_valid_o;
   logic [3:0] ret_value_o;
   logic       ret_ready_i;
   logic       flush_i;
   logic       flush_busy_o;
   logic       flush_done_o;
   logic [3:0] flush_count_o;
   logic       timeout_o;
   logic [1:0] state_o;

   int checks = 0;
   int errors = 0;
   int pull_cnt = 0;
   int to_cnt = 0;
   int p0, r0, t0;
   logic [3:0] vq [$];
   logic [3:0] ret_q [$];

   status_value_retire #(
      .WIDTH(4), .DEPTH(8), .DONE_VALUE(4'hF), .TIMEOUT(4)
   ) dut (
      .clk_i(clk_i), .arst_n_i(arst_n_i),
      .head_valid_i(head_valid_i), .head_value_i(head_value_i), .empty_i(empty_i),
      .pull_o(pull_o), .ret_valid_o(ret_valid_o), .ret_value_o(ret_value_o),
      .ret_ready_i(ret_ready_i), .flush_i(flush_i),
      .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o),
      .flush_count_o(flush_count_o), .timeout_o(timeout_o), .state_o(state_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic refresh_head();
      head_valid_i = (vq.size() > 0);
      head_value_i = (vq.size() > 0) ? vq[0] : 4'h0;
      empty_i      = (vq.size() == 0);
   endtask

   task automatic upd();
      refresh_head();
      #1;
   endtask

   // One clock: sample handshakes just before the edge, then shift the vector model.
   task automatic cyc();
      logic       p, r, t;
      logic [3:0] v;
      #1;
      p = pull_o;
      r = ret_valid_o & ret_ready_i;
      v = ret_value_o;
      t = timeout_o;
      @(posedge clk_i);
      #1;
      if (p && vq.size() > 0) begin
         void'(vq.pop_front());
         pull_cnt++;
      end
      if (r) ret_q.push_back(v);
      if (t) to_cnt++;
      refresh_head();
      @(negedge clk_i);
      #1;
   endtask

   initial begin
      arst_n_i = 1'b1; ret_ready_i = 1'b0; flush_i = 1'b0;
      vq.delete();
      refresh_head();
      #1 arst_n_i = 1'b0;
      @(negedge clk_i); #1;
      chk("rst_pull", pull_o, 0);
      chk("rst_ret_valid", ret_valid_o, 0);
      chk("rst_ret_value", ret_value_o, 0);
      chk("rst_busy", flush_busy_o, 0);
      chk("rst_done", flush_done_o, 0);
      chk("rst_fcount", flush_count_o, 0);
      chk("rst_timeout", timeout_o, 0);
      chk("rst_state", state_o, 0);
      arst_n_i = 1'b1;

      // basic retire
      ret_ready_i = 1'b1;
      vq.push_back(4'h3); upd();
      chk("basic_wait0", pull_o, 0); cyc();
      chk("basic_wait1", pull_o, 0); cyc();
      chk("basic_wait2", pull_o, 0); cyc();
      vq[0] = 4'hF; upd();
      chk("basic_pull", pull_o, 1);
      chk("basic_nvalid", ret_valid_o, 0); cyc();
      chk("basic_valid", ret_valid_o, 1);
      chk("basic_value", ret_value_o, 4'hF);
      chk("basic_nopull", pull_o, 0);
      chk("basic_timeout", timeout_o, 0); cyc();
      chk("basic_drained", ret_valid_o, 0);

      // backpressure
      p0 = pull_cnt; r0 = ret_q.size();
      ret_ready_i = 1'b0;
      repeat (4) vq.push_back(4'hF);
      upd();
      chk("bp_pull0", pull_o, 1); cyc();
      chk("bp_pull1", pull_o, 1); cyc();
      chk("bp_full0", pull_o, 0);
      chk("bp_valid", ret_valid_o, 1); cyc();
      chk("bp_full1", pull_o, 0);
      chk("bp_pulls2", pull_cnt - p0, 2);
      chk("bp_left", vq.size(), 2);
      ret_ready_i = 1'b1; upd();
      chk("bp_still_full", pull_o, 0); cyc();
      chk("bp_pull2", pull_o, 1); cyc();
      chk("bp_pull3", pull_o, 1); cyc();
      chk("bp_empty_vec", pull_o, 0);
      chk("bp_last_valid", ret_valid_o, 1); cyc();
      chk("bp_drained", ret_valid_o, 0);
      chk("bp_pulls4", pull_cnt - p0, 4);
      chk("bp_retired", ret_q.size() - r0, 4);

      // flush of five mixed entries; a done head must not retire on the flush cycle
      p0 = pull_cnt;
      vq.push_back(4'hF); vq.push_back(4'h2); vq.push_back(4'h1);
      vq.push_back(4'h3); vq.push_back(4'h4);
      flush_i = 1'b1; upd();
      chk("fl_gate", pull_o, 0); cyc();
      flush_i = 1'b0; upd();
      for (int k = 0; k < 5; k++) begin
         chk("fl_busy", flush_busy_o, 1);
         chk("fl_pull", pull_o, 1);
         chk("fl_count", flush_count_o, k);
         chk("fl_noret", ret_valid_o, 0);
         cyc();
      end
      chk("fl_busy_end", flush_busy_o, 1);
      chk("fl_pull_end", pull_o, 0);
      chk("fl_count5", flush_count_o, 5); cyc();
      chk("fl_done", flush_done_o, 1);
      chk("fl_busy_off", flush_busy_o, 0);
      chk("fl_count_done", flush_count_o, 5); cyc();
      chk("fl_done_off", flush_done_o, 0);
      chk("fl_count_hold", flush_count_o, 5);
      chk("fl_state_run", state_o, 0);
      chk("fl_pulls", pull_cnt - p0, 5);
      chk("fl_noret_end", ret_valid_o, 0);

      // flush with an occupied buffer
      ret_ready_i = 1'b0; r0 = ret_q.size();
      vq.push_back(4'hF); vq.push_back(4'hF); upd();
      cyc(); cyc();
      chk("fb_full", ret_valid_o, 1);
      chk("fb_vec_empty", vq.size(), 0);
      vq.push_back(4'h1); vq.push_back(4'h2); vq.push_back(4'h3);
      flush_i = 1'b1; upd(); cyc();
      flush_i = 1'b0; upd();
      chk("fb_count_clr", flush_count_o, 0);
      repeat (3) cyc();
      chk("fb_busy", flush_busy_o, 1);
      chk("fb_count3", flush_count_o, 3);
      chk("fb_pull_end", pull_o, 0); cyc();
      chk("fb_done", flush_done_o, 1); cyc();
      chk("fb_state_run", state_o, 0);
      chk("fb_count_hold", flush_count_o, 3);
      chk("fb_kept", ret_valid_o, 1);
      chk("fb_kept_val", ret_value_o, 4'hF);
      ret_ready_i = 1'b1; upd();
      cyc(); cyc();
      chk("fb_drained", ret_valid_o, 0);
      chk("fb_delivered", ret_q.size() - r0, 2);

      // stuck-head timeout
      t0 = to_cnt;
      vq.push_back(4'h1); upd();
      chk("to_0", timeout_o, 0); cyc();
      chk("to_1", timeout_o, 0); cyc();
      chk("to_2", timeout_o, 0); cyc();
      chk("to_3", timeout_o, 0); cyc();
      chk("to_fire", timeout_o, 1); cyc();
      chk("to_once0", timeout_o, 0); cyc();
      chk("to_once1", timeout_o, 0);
      chk("to_nopull", pull_o, 0);
      vq[0] = 4'hF; upd();
      chk("to_pull", pull_o, 1); cyc();
      chk("to_ret", ret_valid_o, 1);
      chk("to_pulses", to_cnt - t0, 1); cyc();

      // async reset in the middle of a flush
      repeat (4) vq.push_back(4'h1);
      flush_i = 1'b1; upd(); cyc();
      flush_i = 1'b0; upd();
      cyc(); cyc();
      chk("ar_count2", flush_count_o, 2);
      chk("ar_busy", flush_busy_o, 1);
      chk("ar_pull", pull_o, 1);
      arst_n_i = 1'b0; #1;
      chk("ar_pull_off", pull_o, 0);
      chk("ar_busy_off", flush_busy_o, 0);
      chk("ar_done_off", flush_done_o, 0);
      chk("ar_count_off", flush_count_o, 0);
      chk("ar_valid_off", ret_valid_o, 0);
      chk("ar_value_off", ret_value_o, 0);
      chk("ar_timeout_off", timeout_o, 0);
      chk("ar_state", state_o, 0);
      cyc();
      chk("ar_hold_pull", pull_o, 0);
      vq.delete();
      arst_n_i = 1'b1;
      vq.push_back(4'hF); upd();
      chk("ar_new_pull", pull_o, 1); cyc();
      chk("ar_new_valid", ret_valid_o, 1);
      chk("ar_new_value", ret_value_o, 4'hF); cyc();

      chk("total_retired", ret_q.size(), 9);
      foreach (ret_q[i]) chk("retired_value", ret_q[i], 4'hF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
